// File: rtl/neuron_pkg.sv
// Shared types and defaults for the time-multiplexed neuron layer scheduler.
// Holds the controller state encoding and the default weight-set vector type.
package neuron_pkg;

   localparam int WIDTH_DEF    = 32;
   localparam int N_INPUTS_DEF = 32;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      LOAD,
      EVAL,
      EMIT,
      FINISH
   } state_t;

   // Weights at index 0..N_INPUTS-1, bias at index N_INPUTS.
   typedef logic [N_INPUTS_DEF:0][WIDTH_DEF-1:0] w_set_t;

endpackage

// File: rtl/neuron_layer_sched_fsm.sv
// Layer sequencing controller: walks neuron indices through
// fetch, load, evaluate and emit, then pulses completion.
module neuron_layer_sched_fsm
   import neuron_pkg::*;
#(
   parameter int N_NEURONS = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       out_ready,
   output state_t     state,
   output logic [7:0] idx
);

   localparam logic [7:0] LAST = 8'(N_NEURONS - 1);

   state_t     state_nxt;
   logic [7:0] idx_nxt;

   // State and neuron index registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         idx   <= '0;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
      end
   end

   // Next-state and index sequencing; start is only honoured in IDLE.
   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      unique case (state)
         IDLE: begin
            if (start) begin
               state_nxt = FETCH;
               idx_nxt   = '0;
            end
         end
         FETCH: state_nxt = LOAD;
         LOAD:  state_nxt = EVAL;
         EVAL:  state_nxt = EMIT;
         EMIT: begin
            if (out_ready) begin
               if (idx == LAST) begin
                  state_nxt = FINISH;
               end else begin
                  state_nxt = FETCH;
                  idx_nxt   = idx + 8'd1;
               end
            end
         end
         FINISH: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: rtl/neuron_layer_sched.sv
// Schedules N_NEURONS evaluations onto one shared external neuron,
// registering its operands and streaming indexed results out.
module neuron_layer_sched
   import neuron_pkg::*;
#(
   parameter int N_INPUTS  = N_INPUTS_DEF,
   parameter int WIDTH     = WIDTH_DEF,
   parameter int N_NEURONS = 8
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           start,
   input  logic [N_INPUTS-1:0][WIDTH-1:0] in_vec,
   output logic                           w_rd_en,
   output logic [7:0]                     w_addr,
   input  logic [N_INPUTS:0][WIDTH-1:0]   w_data,
   output logic [N_INPUTS-1:0][WIDTH-1:0] nrn_in,
   output logic [N_INPUTS:0][WIDTH-1:0]   nrn_const,
   input  logic [WIDTH-1:0]               nrn_out,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [WIDTH-1:0]               out_data,
   output logic [7:0]                     out_idx,
   output logic                           busy,
   output logic                           done
);

   state_t     state;
   logic [7:0] idx;

   neuron_layer_sched_fsm #(
      .N_NEURONS (N_NEURONS)
   ) u_fsm (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .out_ready (out_ready),
      .state     (state),
      .idx       (idx)
   );

   // Operand and result registers, each loaded in its own phase.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         nrn_in    <= '0;
         nrn_const <= '0;
         out_data  <= '0;
         out_idx   <= '0;
      end else begin
         if (state == IDLE && start) begin
            nrn_in <= in_vec;
         end
         if (state == LOAD) begin
            nrn_const <= w_data;
         end
         if (state == EVAL) begin
            out_data <= nrn_out;
            out_idx  <= idx;
         end
      end
   end

   assign w_rd_en   = (state == FETCH);
   assign w_addr    = w_rd_en ? idx : 8'd0;
   assign out_valid = (state == EMIT);
   assign busy      = (state != IDLE);
   assign done      = (state == FINISH);

endmodule

// File: tb/tb_neuron_layer_sched.sv
// Directed bench for neuron_layer_sched with a bias+input[0] neuron
// stub and a one-cycle-latency weight memory.
module tb_neuron_layer_sched;

   localparam int NI = 4;
   localparam int W  = 32;

   logic clk = 1'b0;
   logic rst_n;

   logic                  start, out_ready;
   logic [NI-1:0][W-1:0]  in_vec, nrn_in;
   logic [NI:0][W-1:0]    w_data, nrn_const;
   logic [W-1:0]          nrn_out, out_data;
   logic [7:0]            w_addr, out_idx;
   logic                  w_rd_en, out_valid, busy, done;

   logic                  start1, out_ready1;
   logic [NI-1:0][W-1:0]  in_vec1, nrn_in1;
   logic [NI:0][W-1:0]    w_data1, nrn_const1;
   logic [W-1:0]          nrn_out1, out_data1;
   logic [7:0]            w_addr1, out_idx1;
   logic                  w_rd_en1, out_valid1, busy1, done1;

   int errors = 0;
   int checks = 0;

   logic [W-1:0] r_data [8];
   logic [7:0]   r_idx  [8];
   int n_res, done_cyc, stall_rd, stall_data, stall_cnt;

   always #5 clk = ~clk;

   neuron_layer_sched #(
      .N_INPUTS (NI), .WIDTH (W), .N_NEURONS (4)
   ) dut (
      .clk (clk), .rst_n (rst_n), .start (start), .in_vec (in_vec),
      .w_rd_en (w_rd_en), .w_addr (w_addr), .w_data (w_data),
      .nrn_in (nrn_in), .nrn_const (nrn_const), .nrn_out (nrn_out),
      .out_valid (out_valid), .out_ready (out_ready),
      .out_data (out_data), .out_idx (out_idx),
      .busy (busy), .done (done)
   );

   neuron_layer_sched #(
      .N_INPUTS (NI), .WIDTH (W), .N_NEURONS (1)
   ) dut1 (
      .clk (clk), .rst_n (rst_n), .start (start1), .in_vec (in_vec1),
      .w_rd_en (w_rd_en1), .w_addr (w_addr1), .w_data (w_data1),
      .nrn_in (nrn_in1), .nrn_const (nrn_const1), .nrn_out (nrn_out1),
      .out_valid (out_valid1), .out_ready (out_ready1),
      .out_data (out_data1), .out_idx (out_idx1),
      .busy (busy1), .done (done1)
   );

   assign nrn_out  = nrn_const[NI] + nrn_in[0];
   assign nrn_out1 = nrn_const1[NI] + nrn_in1[0];

   // weight set k: weights 8, bias 100*k
   always @(posedge clk) begin
      if (w_rd_en) begin
         for (int k = 0; k < NI; k++) w_data[k] <= 32'd8;
         w_data[NI] <= 32'd100 * {24'd0, w_addr};
      end
   end

   // single-neuron memory: bias 42
   always @(posedge clk) begin
      if (w_rd_en1) begin
         for (int k = 0; k < NI; k++) w_data1[k] <= 32'd8;
         w_data1[NI] <= 32'd42;
      end
   end

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic run_layer(input int stall_idx, input int stall_len,
                            input bit inject);
      n_res = 0; done_cyc = -1;
      stall_rd = 0; stall_data = 0; stall_cnt = 0;
      in_vec = {NI{32'd5}};
      start = 1'b1;
      out_ready = 1'b1;
      step();
      for (int cyc = 1; cyc <= 200; cyc++) begin
         start = 1'b0;
         if (inject && (cyc == 3 || cyc == 9)) begin
            start = 1'b1;
            in_vec = {NI{32'd7}};
         end
         out_ready = 1'b1;
         if (out_valid && int'(out_idx) == stall_idx && stall_cnt < stall_len) begin
            out_ready = 1'b0;
            stall_cnt++;
            if (w_rd_en) stall_rd++;
            if (out_data !== 32'd105) stall_data++;
         end
         if (out_valid && out_ready && n_res < 8) begin
            r_data[n_res] = out_data;
            r_idx[n_res]  = out_idx;
            n_res++;
         end
         if (done) begin
            done_cyc = cyc;
            break;
         end
         step();
      end
      start = 1'b0;
      out_ready = 1'b1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; start = 1'b0; start1 = 1'b0;
      out_ready = 1'b1; out_ready1 = 1'b1;
      in_vec = '0; in_vec1 = '0;
      step(); step();
      checks += 9;
      if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %0b want 0", busy); end
      if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %0b want 0", done); end
      if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %0b want 0", out_valid); end
      if (w_rd_en !== 1'b0) begin errors++; $display("FAIL rst_rd_en: got %0b want 0", w_rd_en); end
      if (w_addr !== 8'd0) begin errors++; $display("FAIL rst_addr: got %0d want 0", w_addr); end
      if (out_data !== 32'd0) begin errors++; $display("FAIL rst_data: got %0d want 0", out_data); end
      if (out_idx !== 8'd0) begin errors++; $display("FAIL rst_idx: got %0d want 0", out_idx); end
      if (nrn_in !== '0) begin errors++; $display("FAIL rst_nrn_in: got %h want 0", nrn_in); end
      if (nrn_const !== '0) begin errors++; $display("FAIL rst_nrn_const: got %h want 0", nrn_const); end
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_layer;
      run_layer(-1, 0, 1'b0);
      checks++;
      if (n_res != 4) begin errors++; $display("FAIL layer_count: got %0d want 4", n_res); end
      for (int i = 0; i < 4 && i < n_res; i++) begin
         checks += 2;
         if (r_data[i] !== 32'(5 + 100 * i)) begin
            errors++; $display("FAIL layer_data%0d: got %0d want %0d", i, r_data[i], 5 + 100 * i);
         end
         if (r_idx[i] !== 8'(i)) begin
            errors++; $display("FAIL layer_idx%0d: got %0d want %0d", i, r_idx[i], i);
         end
      end
      checks++;
      if (done_cyc != 17) begin errors++; $display("FAIL layer_done_cyc: got %0d want 17", done_cyc); end
      step();
   endtask

   task automatic test_stall;
      run_layer(1, 10, 1'b0);
      checks += 5;
      if (n_res != 4) begin errors++; $display("FAIL stall_count: got %0d want 4", n_res); end
      if (stall_cnt != 10) begin errors++; $display("FAIL stall_len: got %0d want 10", stall_cnt); end
      if (stall_rd != 0) begin errors++; $display("FAIL stall_rd_en: got %0d reads want 0", stall_rd); end
      if (stall_data != 0) begin errors++; $display("FAIL stall_hold: got %0d bad cycles want 0", stall_data); end
      if (done_cyc != 27) begin errors++; $display("FAIL stall_done_cyc: got %0d want 27", done_cyc); end
      for (int i = 0; i < 4 && i < n_res; i++) begin
         checks++;
         if (r_data[i] !== 32'(5 + 100 * i) || r_idx[i] !== 8'(i)) begin
            errors++; $display("FAIL stall_order%0d: got %0d/%0d want %0d/%0d",
                               i, r_data[i], r_idx[i], 5 + 100 * i, i);
         end
      end
      step();
   endtask

   task automatic test_ignore_start;
      run_layer(-1, 0, 1'b1);
      checks += 2;
      if (n_res != 4) begin errors++; $display("FAIL ign_count: got %0d want 4", n_res); end
      if (done_cyc != 17) begin errors++; $display("FAIL ign_done_cyc: got %0d want 17", done_cyc); end
      for (int i = 0; i < 4 && i < n_res; i++) begin
         checks++;
         if (r_data[i] !== 32'(5 + 100 * i)) begin
            errors++; $display("FAIL ign_data%0d: got %0d want %0d", i, r_data[i], 5 + 100 * i);
         end
      end
      step();
      checks++;
      if (nrn_in[0] !== 32'd5) begin errors++; $display("FAIL ign_nrn_in: got %0d want 5", nrn_in[0]); end
   endtask

   task automatic test_reset_mid;
      bit hit;
      in_vec = {NI{32'd5}};
      start = 1'b1;
      step();
      start = 1'b0;
      checks += 3;
      if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy: got %0b want 1", busy); end
      if (w_rd_en !== 1'b1) begin errors++; $display("FAIL mid_rd_en: got %0b want 1", w_rd_en); end
      if (w_addr !== 8'd0) begin errors++; $display("FAIL mid_addr: got %0d want 0", w_addr); end
      hit = 1'b0;
      for (int c = 0; c < 40; c++) begin
         if (w_rd_en && w_addr == 8'd2) begin hit = 1'b1; break; end
         step();
      end
      checks++;
      if (!hit) begin errors++; $display("FAIL mid_fetch2: got timeout want fetch of idx 2"); end
      step();
      rst_n = 1'b0;
      step();
      checks += 4;
      if (busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy: got %0b want 0", busy); end
      if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %0b want 0", out_valid); end
      if (nrn_const !== '0) begin errors++; $display("FAIL mid_rst_const: got %h want 0", nrn_const); end
      if (nrn_in !== '0) begin errors++; $display("FAIL mid_rst_in: got %h want 0", nrn_in); end
      rst_n = 1'b1;
      step(); step();
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL mid_idle: got valid=%0b busy=%0b want 0/0", out_valid, busy);
      end
      run_layer(-1, 0, 1'b0);
      checks += 3;
      if (n_res != 4) begin errors++; $display("FAIL mid_count: got %0d want 4", n_res); end
      if (n_res > 0 && (r_idx[0] !== 8'd0 || r_data[0] !== 32'd5)) begin
         errors++; $display("FAIL mid_first: got %0d/%0d want 5/0", r_data[0], r_idx[0]);
      end
      if (done_cyc != 17) begin errors++; $display("FAIL mid_done_cyc: got %0d want 17", done_cyc); end
      step();
   endtask

   task automatic test_start_on_done;
      bit fin;
      run_layer(-1, 0, 1'b0);
      checks++;
      if (done_cyc != 17) begin errors++; $display("FAIL sod_done_cyc: got %0d want 17", done_cyc); end
      start = 1'b1;
      step();
      checks += 2;
      if (busy !== 1'b0) begin errors++; $display("FAIL sod_ignored: got busy=%0b want 0", busy); end
      if (done !== 1'b0) begin errors++; $display("FAIL sod_done_pulse: got %0b want 0", done); end
      step();
      start = 1'b0;
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL sod_accept: got busy=%0b want 1", busy); end
      fin = 1'b0;
      for (int c = 0; c < 100; c++) begin
         if (done) begin fin = 1'b1; break; end
         step();
      end
      checks++;
      if (!fin) begin errors++; $display("FAIL sod_finish: got timeout want done"); end
      step();
   endtask

   task automatic test_single;
      int cnt, dc;
      logic [W-1:0] d;
      logic [7:0] ix;
      cnt = 0; dc = -1; d = '0; ix = 8'hff;
      in_vec1 = '0;
      start1 = 1'b1;
      step();
      for (int cyc = 1; cyc <= 50; cyc++) begin
         start1 = 1'b0;
         if (out_valid1) begin
            d = out_data1; ix = out_idx1; cnt++;
         end
         if (done1) begin dc = cyc; break; end
         step();
      end
      checks += 4;
      if (cnt != 1) begin errors++; $display("FAIL single_count: got %0d want 1", cnt); end
      if (d !== 32'd42) begin errors++; $display("FAIL single_data: got %0d want 42", d); end
      if (ix !== 8'd0) begin errors++; $display("FAIL single_idx: got %0d want 0", ix); end
      if (dc != 5) begin errors++; $display("FAIL single_done_cyc: got %0d want 5", dc); end
      step();
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      start1 = 1'b0;
      out_ready = 1'b1;
      out_ready1 = 1'b1;
      in_vec = '0;
      in_vec1 = '0;
      test_reset();
      test_layer();
      test_stall();
      test_ignore_start();
      test_reset_mid();
      test_start_on_done();
      test_single();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/neuron_layer_sched.md
NEURON_LAYER_SCHED -- requirements
Module: neuron_layer_sched

Interface
REQ-001 Parameter N_INPUTS, default 32, inputs per neuron.
REQ-002 Parameter WIDTH, default 32, bits per input, weight, bias and output.
REQ-003 Parameter N_NEURONS, default 8, neurons time-multiplexed onto one shared neuron datapath (range 1..256).
REQ-004 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 Port rst_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-006 Port start  input  1  one-cycle request to evaluate the whole layer.
REQ-007 Port in_vec  input  N_INPUTS x WIDTH  layer input vector, captured when start is accepted.
REQ-008 Port w_rd_en  output  1  weight memory read strobe.
REQ-009 Port w_addr  output  8  neuron index of the weight set being read.
REQ-010 Port w_data  input  (N_INPUTS+1) x WIDTH  weight set (index 0..N_INPUTS-1 weights, index N_INPUTS bias), valid exactly 1 cycle after w_rd_en.
REQ-011 Port nrn_in  output  N_INPUTS x WIDTH  registered input vector to the shared neuron.
REQ-012 Port nrn_const  output  (N_INPUTS+1) x WIDTH  registered weight set to the shared neuron.
REQ-013 Port nrn_out  input  WIDTH  combinational neuron result.
REQ-014 Port out_valid / out_ready  output / input  1 / 1  result stream handshake.
REQ-015 Port out_data / out_idx  output / output  WIDTH / 8  neuron result and its neuron index.
REQ-016 Port busy / done  output / output  1 / 1  layer in progress; one-cycle completion pulse.

Function
REQ-017 FSM states: IDLE, FETCH, LOAD, EVAL, EMIT, FINISH.
REQ-018 IDLE: start=1 -> capture in_vec into nrn_in, idx=0, go FETCH; otherwise stay.
REQ-019 FETCH: w_rd_en=1, w_addr=idx for exactly this one cycle; go LOAD.
REQ-020 LOAD: register w_data into nrn_const; go EVAL.
REQ-021 EVAL: register nrn_out into out_data, idx into out_idx; go EMIT.
REQ-022 EMIT: out_valid=1; out_data/out_idx held stable until out_valid && out_ready; on transfer, idx==N_NEURONS-1 -> FINISH, else idx+1 -> FETCH.
REQ-023 FINISH: done=1 one cycle; go IDLE.
REQ-024 busy=1 in every state except IDLE; start while busy is ignored (not queued).
REQ-025 Minimum per-neuron latency 4 cycles (FETCH..EMIT with out_ready=1); layer start-to-done = 4*N_NEURONS+1 cycles with out_ready held high.
REQ-026 nrn_in constant from acceptance of start until next accepted start; in_vec changes mid-layer have no effect.
REQ-027 out_ready low stalls in EMIT indefinitely; no weight read issued while stalled.
REQ-028 Results emitted strictly in idx order 0..N_NEURONS-1, each exactly once.
REQ-029 start in the same cycle as done (FINISH) ignored; accepted from the following IDLE cycle.
REQ-030 N_NEURONS=1: FETCH, LOAD, EVAL, EMIT, FINISH with idx 0 only.

Reset
REQ-031 rst_n=0 at any rising edge, including mid-layer or mid-stall: state=IDLE, idx=0, busy=0, done=0, out_valid=0, w_rd_en=0, w_addr=0, out_data=0, out_idx=0, nrn_in=0, nrn_const=0; in-flight layer discarded, no partial results emitted after release.

Structure
REQ-032 Shared package neuron_pkg holds WIDTH/N_INPUTS defaults, the FSM state enum and the weight-set vector typedef.
REQ-033 Shared neuron datapath instantiated outside this block; one sub-module natural: neuron_layer_sched_fsm (state/idx), datapath registers in top.

Verification
REQ-034 Bench stub: neuron returns bias + nrn_in[0]; memory set k = weights 8, bias 100*k; N_NEURONS=4, in_vec all 5, out_ready=1 -> out_data 5,105,205,305 with out_idx 0..3, done at cycle 17 after start.
REQ-035 Same, out_ready low 10 cycles during idx 1 EMIT -> out_data=105 held, w_rd_en=0 throughout stall, order preserved.
REQ-036 start pulsed at cycles 3 and 9 of a layer, in_vec changed to 7 -> ignored; all results use 5.
REQ-037 rst_n=0 one cycle while in LOAD of idx 2 -> next cycle busy=0, out_valid=0; new start -> idx restarts at 0.
REQ-038 start coincident with done -> ignored; start next cycle -> accepted, busy=1.
REQ-039 N_NEURONS=1, bias 42, in_vec 0 -> single result 42, idx 0, done 5 cycles after start.
